// File: rtl/chip_74157n_emulator_if.sv
// Socket-side pin bundle for the 74157 emulator: select/strobe/data pins in,
// Y pins out, plus the vector counter and fault-injection controls.
interface chip_74157n_emulator_if #(
  parameter int CNT_W = 8
);
  logic             Pin1, Pin2, Pin3, Pin5, Pin6, Pin11, Pin10, Pin14, Pin13, Pin15;
  logic             Pin4, Pin7, Pin9, Pin12;
  logic             Count_Clr;
  logic [CNT_W-1:0] Vec_Count;
  logic             Fault_Load;
  logic [1:0]       Fault_Lane;
  logic [1:0]       Fault_Type;
  logic             Fault_Clr;
  logic             Fault_Active;

  modport master (
    output Pin1, Pin2, Pin3, Pin5, Pin6, Pin11, Pin10, Pin14, Pin13, Pin15,
    output Count_Clr, Fault_Load, Fault_Lane, Fault_Type, Fault_Clr,
    input  Pin4, Pin7, Pin9, Pin12, Vec_Count, Fault_Active
  );

  modport slave (
    input  Pin1, Pin2, Pin3, Pin5, Pin6, Pin11, Pin10, Pin14, Pin13, Pin15,
    input  Count_Clr, Fault_Load, Fault_Lane, Fault_Type, Fault_Clr,
    output Pin4, Pin7, Pin9, Pin12, Vec_Count, Fault_Active
  );
endinterface

// File: rtl/chip_74157n_emulator.sv
// Cycle-accurate 74157 quad 2:1 selector stand-in with registered Y pins.
// Fault injection is built only when CHIP_74157N_FAULT_INJECT_EN is defined.

// One selector lane with its optional fault override.
module chip_74157n_lane (
  input  logic       a,
  input  logic       b,
  input  logic       s,
  input  logic       g_n,
  input  logic       fault_on,
  input  logic [1:0] fault_type,
  output logic       y
);
  logic f;
  assign f = g_n ? 1'b0 : (s ? b : a);

  always_comb begin
    y = f;
    if (fault_on) begin
      case (fault_type)
        2'b01:   y = 1'b0;
        2'b10:   y = 1'b1;
        2'b11:   y = ~f;
        default: y = f;
      endcase
    end
  end
endmodule

module chip_74157n_emulator #(
  parameter int PROP_DELAY = 2,   // 1..8
  parameter int CNT_W      = 8
) (
  input logic                    Clk,
  input logic                    Reset,
  chip_74157n_emulator_if.slave  bus
);
  localparam int NUM_LANES = 4;

  // V = {S, G_n, A[3:0], B[3:0]}
  logic [9:0] pins, sync1_q, sync2_q, prev_q;
  logic       v_s, v_g_n, vec_chg;
  logic [NUM_LANES-1:0] v_a, v_b, y_d, fault_hit;
  logic [1:0] fault_type;
  logic [PROP_DELAY-1:0][NUM_LANES-1:0] pipe_q;
  logic [CNT_W-1:0] cnt_q;

  assign pins = {bus.Pin1, bus.Pin15,
                 bus.Pin14, bus.Pin11, bus.Pin5, bus.Pin2,
                 bus.Pin13, bus.Pin10, bus.Pin6, bus.Pin3};

  assign v_s     = sync2_q[9];
  assign v_g_n   = sync2_q[8];
  assign v_a     = sync2_q[7:4];
  assign v_b     = sync2_q[3:0];
  assign vec_chg = (sync2_q != prev_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Saturating change counter; clear beats a coincident increment.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                        cnt_q <= '0;
    else if (bus.Count_Clr)           cnt_q <= '0;
    else if (vec_chg && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

`ifdef CHIP_74157N_FAULT_INJECT_EN
  typedef enum logic [1:0] {F_IDLE, F_ARMED, F_ACTIVE} fstate_e;
  fstate_e    state_q, state_d;
  logic       latch_cfg;
  logic [1:0] lane_q, type_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= F_IDLE;
      lane_q  <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        lane_q <= bus.Fault_Lane;
        type_q <= bus.Fault_Type;
      end
    end
  end

  // A fresh load always re-arms, so an active fault drops out immediately.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    if (bus.Fault_Clr)
      state_d = F_IDLE;
    else if (bus.Fault_Load && bus.Fault_Type == 2'b00)
      state_d = F_IDLE;
    else if (bus.Fault_Load) begin
      state_d   = F_ARMED;
      latch_cfg = 1'b1;
    end else if (state_q == F_ARMED && vec_chg)
      state_d = F_ACTIVE;
  end

  assign fault_type       = type_q;
  assign bus.Fault_Active = (state_q == F_ACTIVE);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_hit
    assign fault_hit[i] = (state_q == F_ACTIVE) && (lane_q == 2'(i));
  end
`else
  logic unused_fault;
  assign unused_fault     = ^{bus.Fault_Load, bus.Fault_Lane, bus.Fault_Type, bus.Fault_Clr};
  assign fault_type       = 2'b00;
  assign fault_hit        = '0;
  assign bus.Fault_Active = 1'b0;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    chip_74157n_lane u_lane (
      .a          (v_a[i]),
      .b          (v_b[i]),
      .s          (v_s),
      .g_n        (v_g_n),
      .fault_on   (fault_hit[i]),
      .fault_type (fault_type),
      .y          (y_d[i])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= y_d;
      for (int i = 1; i < PROP_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.Pin4      = pipe_q[PROP_DELAY-1][0];
  assign bus.Pin7      = pipe_q[PROP_DELAY-1][1];
  assign bus.Pin9      = pipe_q[PROP_DELAY-1][2];
  assign bus.Pin12     = pipe_q[PROP_DELAY-1][3];
  assign bus.Vec_Count = cnt_q;
endmodule
